// File: rtl/aes_128_dec_iter.sv
// ---------------------------------------------------------------------------
// aes_128_dec_iter -- iterative AES-128 decryption core.
//
// This core recovers the plaintext from a ciphertext and the original
// 128-bit cipher key. The sequence for one block is:
//   1. Expand the key forward to round key 10, one round key per cycle.
//   2. Add round key 10 to the state.
//   3. Run nine inverse rounds, one per cycle. Each round first rolls the
//      key schedule back by one step.
//   4. Run the final inverse round, which has no InvMixColumns.
// With the key cache disabled, the result appears 21 cycles after accept.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   request valid
//   in_ready   core can accept a request (high only in IDLE)
//   state      ciphertext, byte 0 at [127:120]
//   key        original cipher key, same byte order
//   out_valid  plaintext valid; held until out_ready
//   out_ready  consumer accepts plaintext
//   out        plaintext
//
// Optional build macro: AES_DEC_KEY_CACHE_EN.
//   When defined, round key 10 of the last expanded key is remembered.
//   A request with the same key skips key expansion and completes
//   11 cycles after accept.
//
// The S-box leaf modules aes_sbox and aes_inv_sbox are also in this file.
// They compute the byte mapping arithmetically: a GF(2^8) inverse plus
// the affine transform.
// ---------------------------------------------------------------------------

// Forward S-box. The output is affine(x^-1) in GF(2^8).
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // x^254 equals x^-1 for nonzero x, and 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv_a;
    assign inv_a = gf_inv(a);
    assign y = inv_a ^ {inv_a[6:0], inv_a[7]} ^ {inv_a[5:0], inv_a[7:6]}
             ^ {inv_a[4:0], inv_a[7:5]} ^ {inv_a[3:0], inv_a[7:4]} ^ 8'h63;
endmodule

// Inverse S-box. It applies the inverse affine transform, then the GF(2^8) inverse.
module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] m);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = x;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) acc = acc ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = x;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] pre;
    assign pre = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    assign y   = gf_inv(pre);
endmodule

module aes_128_dec_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out
);
    typedef enum logic [2:0] {IDLE, KEYEXP, ADD, ROUND, FINAL, DONE} fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [3:0]   rcnt_reg;
    logic [127:0] s_reg;
    logic [127:0] rk_reg;
    logic [127:0] out_reg;
    logic         out_valid_reg;
    logic         in_ready_reg;

    logic accept;
    logic xfer;
    assign accept = in_valid & in_ready_reg;
    assign xfer   = out_valid_reg & out_ready;

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // InvShiftRows: out[r,c] = in[r,(c-r) mod 4], where byte index = r + 4c.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = x[127 - 8*(r + 4*((c - r + 4) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] x);
        logic [127:0] o;
        logic [7:0]   a [4];
        logic [7:0]   m9 [4];
        logic [7:0]   m11 [4];
        logic [7:0]   m13 [4];
        logic [7:0]   m14 [4];
        logic [7:0]   d2, d4, d8;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                a[r]   = x[127 - 8*(r + 4*c) -: 8];
                d2     = xt(a[r]);
                d4     = xt(d2);
                d8     = xt(d4);
                m9[r]  = d8 ^ a[r];
                m11[r] = d8 ^ d2 ^ a[r];
                m13[r] = d8 ^ d4 ^ a[r];
                m14[r] = d8 ^ d4 ^ d2;
            end
            o[127 - 8*(4*c)     -: 8] = m14[0] ^ m11[1] ^ m13[2] ^ m9[3];
            o[127 - 8*(4*c + 1) -: 8] = m9[0]  ^ m14[1] ^ m11[2] ^ m13[3];
            o[127 - 8*(4*c + 2) -: 8] = m13[0] ^ m9[1]  ^ m14[2] ^ m11[3];
            o[127 - 8*(4*c + 3) -: 8] = m11[0] ^ m13[1] ^ m9[2]  ^ m14[3];
        end
        return o;
    endfunction

    // Key schedule. The forward and backward steps share one SubWord.
    // Forward expansion feeds it w3. Backward expansion feeds it the
    // recovered w3, which is w3 ^ w2.
    logic [31:0] w0, w1, w2, w3;
    logic [31:0] iw0, iw1, iw2, iw3;
    logic [31:0] f0, f1, f2, f3;
    logic [31:0] sub_src, rot_word, sub_word, rcon_word;
    logic [127:0] rk_fwd, rk_inv;

    assign {w0, w1, w2, w3} = rk_reg;
    assign iw3       = w3 ^ w2;
    assign iw2       = w2 ^ w1;
    assign iw1       = w1 ^ w0;
    assign sub_src   = (fsm_reg == KEYEXP) ? w3 : iw3;
    assign rot_word  = {sub_src[23:0], sub_src[31:24]};
    assign rcon_word = {rcon(rcnt_reg), 24'h0};

    for (genvar gi = 0; gi < 4; gi++) begin : g_key_sbox
        aes_sbox u_sbox (
            .a (rot_word[31 - 8*gi -: 8]),
            .y (sub_word[31 - 8*gi -: 8])
        );
    end

    assign f0     = w0 ^ sub_word ^ rcon_word;
    assign f1     = w1 ^ f0;
    assign f2     = w2 ^ f1;
    assign f3     = w3 ^ f2;
    assign rk_fwd = {f0, f1, f2, f3};
    assign iw0    = w0 ^ sub_word ^ rcon_word;
    assign rk_inv = {iw0, iw1, iw2, iw3};

    // Data path: InvShiftRows, InvSubBytes, then add the rolled-back round key.
    logic [127:0] isr, isb, added, round_out;
    assign isr = inv_shift_rows(s_reg);

    for (genvar gi = 0; gi < 16; gi++) begin : g_data_sbox
        aes_inv_sbox u_inv_sbox (
            .a (isr[127 - 8*gi -: 8]),
            .y (isb[127 - 8*gi -: 8])
        );
    end

    assign added     = isb ^ rk_inv;
    assign round_out = inv_mix_columns(added);

`ifdef AES_DEC_KEY_CACHE_EN
    logic [127:0] last_key_reg;
    logic [127:0] rk10_cache_reg;
    logic         cache_valid_reg;
    logic         cache_hit;
    assign cache_hit = cache_valid_reg && (key == last_key_reg);
`endif

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            IDLE: begin
                if (accept) begin
`ifdef AES_DEC_KEY_CACHE_EN
                    fsm_next = cache_hit ? ADD : KEYEXP;
`else
                    fsm_next = KEYEXP;
`endif
                end
            end
            KEYEXP:  if (rcnt_reg == 4'd10) fsm_next = ADD;
            ADD:     fsm_next = ROUND;
            // The round with rcnt == 2 produces rk1, which is the last full round.
            ROUND:   if (rcnt_reg == 4'd2) fsm_next = FINAL;
            FINAL:   fsm_next = DONE;
            DONE:    if (xfer) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_reg       <= IDLE;
            rcnt_reg      <= 4'd0;
            s_reg         <= '0;
            rk_reg        <= '0;
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b0;
`ifdef AES_DEC_KEY_CACHE_EN
            last_key_reg    <= '0;
            rk10_cache_reg  <= '0;
            cache_valid_reg <= 1'b0;
`endif
        end else begin
            fsm_reg      <= fsm_next;
            // in_ready is registered. It therefore stays low on the cycle
            // after reset and on the cycle of a transfer.
            in_ready_reg <= (fsm_next == IDLE);
            case (fsm_reg)
                IDLE: begin
                    if (accept) begin
                        s_reg    <= state;
                        rk_reg   <= key;
                        rcnt_reg <= 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
                        if (cache_hit) begin
                            rk_reg <= rk10_cache_reg;
                        end else begin
                            last_key_reg    <= key;
                            cache_valid_reg <= 1'b0;
                        end
`endif
                    end
                end
                KEYEXP: begin
                    rk_reg   <= rk_fwd;
                    rcnt_reg <= rcnt_reg + 4'd1;
`ifdef AES_DEC_KEY_CACHE_EN
                    if (rcnt_reg == 4'd10) begin
                        rk10_cache_reg  <= rk_fwd;
                        cache_valid_reg <= 1'b1;
                    end
`endif
                end
                ADD: begin
                    s_reg    <= s_reg ^ rk_reg;
                    rcnt_reg <= 4'd10;
                end
                ROUND: begin
                    rk_reg   <= rk_inv;
                    rcnt_reg <= rcnt_reg - 4'd1;
                    s_reg    <= round_out;
                end
                FINAL: begin
                    // rcnt is 1 here, so rk_inv is round key 0.
                    rk_reg        <= rk_inv;
                    rcnt_reg      <= rcnt_reg - 4'd1;
                    out_reg       <= added;
                    out_valid_reg <= 1'b1;
                end
                DONE: begin
                    if (out_ready) out_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign out       = out_reg;
endmodule

// File: tb/tb_aes_128_dec_iter.sv
module tb_aes_128_dec_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] state;
    logic [127:0] key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef AES_DEC_KEY_CACHE_EN
    localparam int HIT_LAT = 11;
`else
    localparam int HIT_LAT = 21;
`endif

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

    aes_128_dec_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .state     (state),
        .key       (key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clk = ~clk;

    // Reference encryptor, used to make (key, ciphertext) pairs for the random test.
    logic [7:0] sb [256];

    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    s[rr + 4*c] = t[rr + 4*((c + rr) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    // Waits for in_ready, issues one request, then counts edges until out_valid.
    task automatic send(input logic [127:0] k, input logic [127:0] ct,
                        output int lat, output bit timeout);
        int guard;
        timeout = 1'b0;
        lat     = 0;
        guard   = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!in_ready) begin
            timeout = 1'b1;
            return;
        end
        key = k; state = ct; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; state = '0; key = '0;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out !== 128'h0) begin
            tests_failed++;
            $display("FAIL reset_state: got in_ready=%b out_valid=%b out=%h, want 0 0 0", in_ready, out_valid, out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
    endtask

    task automatic test_c1();
        int lat; bit to;
        out_ready = 1'b1;
        send(C1_KEY, C1_CT, lat, to);
        $display("[TB] txn c1 lat=%0d out=%h", lat, out);
        tests_run++;
        if (to || out !== C1_PT) begin
            tests_failed++;
            $display("FAIL c1_out: got %h (timeout=%0b) want %h", out, to, C1_PT);
        end
        tests_run++;
        if (lat != 21) begin
            tests_failed++;
            $display("FAIL c1_latency: got %0d want 21", lat);
        end
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL c1_valid_one_cycle: got out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_fips_b();
        int lat; bit to;
        out_ready = 1'b1;
        send(B_KEY, B_CT, lat, to);
        $display("[TB] txn fips_b lat=%0d out=%h", lat, out);
        tests_run++;
        if (to || out !== B_PT) begin
            tests_failed++;
            $display("FAIL fips_b_out: got %h (timeout=%0b) want %h", out, to, B_PT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat; bit to;
        out_ready = 1'b0;
        send(C1_KEY, C1_CT, lat, to);
        $display("[TB] txn bp_c1 lat=%0d out=%h", lat, out);
        tests_run++;
        if (to) begin
            tests_failed++;
            $display("FAIL bp_timeout: got no out_valid want out_valid within budget");
        end
        // Keep a second request pending while the output is stalled.
        key = B_KEY; state = B_CT; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (out_valid !== 1'b1 || out !== C1_PT || in_ready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_hold%0d: got out_valid=%b out=%h in_ready=%b want 1 %h 0", i, out_valid, out, in_ready, C1_PT);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL bp_after_xfer: got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_second_accept: got in_ready=%b want 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("[TB] txn bp_b lat=%0d out=%h", lat, out);
        tests_run++;
        if (out_valid !== 1'b1 || out !== B_PT || lat != 21) begin
            tests_failed++;
            $display("FAIL bp_second_result: got out=%h lat=%0d want %h lat=21", out, lat, B_PT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midop();
        int lat; bit to;
        out_ready = 1'b1;
        key = C1_KEY; state = C1_CT; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || out !== 128'h0 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL midop_reset: got out_valid=%b out=%h in_ready=%b want 0 0 0", out_valid, out, in_ready);
        end
        @(posedge clk); #1;
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL midop_in_ready: got %b want 1", in_ready);
        end
        send(B_KEY, B_CT, lat, to);
        $display("[TB] txn midop_b lat=%0d out=%h", lat, out);
        tests_run++;
        if (to || out !== B_PT || lat != 21) begin
            tests_failed++;
            $display("FAIL midop_result: got out=%h lat=%0d want %h lat=21", out, lat, B_PT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat; bit to;
        out_ready = 1'b1;
        send(C1_KEY, C1_CT, lat, to);
        $display("[TB] txn b2b_1 lat=%0d out=%h", lat, out);
        tests_run++;
        if (to || out !== C1_PT || lat != 21) begin
            tests_failed++;
            $display("FAIL b2b_first: got out=%h lat=%0d want %h lat=21", out, lat, C1_PT);
        end
        send(C1_KEY, C1_CT, lat, to);
        $display("[TB] txn b2b_2 lat=%0d out=%h", lat, out);
        tests_run++;
        if (to || out !== C1_PT || lat != HIT_LAT) begin
            tests_failed++;
            $display("FAIL b2b_same_key: got out=%h lat=%0d want %h lat=%0d", out, lat, C1_PT, HIT_LAT);
        end
        send(B_KEY, B_CT, lat, to);
        $display("[TB] txn b2b_3 lat=%0d out=%h", lat, out);
        tests_run++;
        if (to || out !== B_PT || lat != 21) begin
            tests_failed++;
            $display("FAIL b2b_new_key: got out=%h lat=%0d want %h lat=21", out, lat, B_PT);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random(input int n);
        logic [127:0] k, pt, ct, d_pre;
        bit ov_pre, done;
        int guard;
        for (int t = 0; t < n; t++) begin
            k  = {$urandom, $urandom, $urandom, $urandom};
            pt = {$urandom, $urandom, $urandom, $urandom};
            ct = aes_enc(k, pt);
            out_ready = 1'b0;
            guard = 0;
            while (!in_ready && guard < 50) begin
                @(posedge clk); #1;
                guard++;
            end
            key = k; state = ct; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            done  = 1'b0;
            guard = 0;
            while (!done && guard < 200) begin
                ov_pre    = out_valid;
                d_pre     = out;
                out_ready = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                guard++;
                if (ov_pre && out_ready) begin
                    done = 1'b1;
                    $display("[TB] txn rnd%0d out=%h", t, d_pre);
                    tests_run++;
                    if (d_pre !== pt) begin
                        tests_failed++;
                        $display("FAIL rnd%0d_out: got %h want %h", t, d_pre, pt);
                    end
                end else if (ov_pre) begin
                    tests_run++;
                    if (out_valid !== 1'b1 || out !== d_pre) begin
                        tests_failed++;
                        $display("FAIL rnd%0d_hold: got out_valid=%b out=%h want 1 %h", t, out_valid, out, d_pre);
                    end
                end
            end
            if (!done) begin
                tests_run++;
                tests_failed++;
                $display("FAIL rnd%0d_timeout: got no transfer want transfer within 200 cycles", t);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_c1();
        test_fips_b();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        test_random(200);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
